// File: rtl/pic_command_sequencer.sv
// pic_command_sequencer
//   ICW/OCW command sequencer for an 8259-style PIC. It decodes CPU writes
//   (A0 plus a data byte) and walks the ICW1 -> ICW2 -> [ICW3] -> [ICW4]
//   initialisation sequence. It holds every configuration field and emits
//   one-cycle OCW2 command pulses and OCW3 read/poll controls.
//
//   Optional feature macro: PIC_SPECIAL_MASK_EN
//     When defined, OCW3 with ESMM=1 loads special_mask_mode from SMM (D5).
//     When undefined, special_mask_mode is tied to 0.
//
// Ports
//   clock, reset                    : clock; asynchronous active-high reset
//   write_strobe, A0, data_in       : qualified CPU write (one cycle per write)
//   init_busy, pic_ready            : sequencer status
//   level_or_edge_triggered_config  : ICW1 LTIM
//   single_or_cascade_config        : ICW1 SNGL
//   vector_base                     : ICW2 D7..D3
//   cascade_config                  : ICW3 byte
//   special_fully_nest_config       : ICW4 SFNM
//   buffered_mode_config            : ICW4 {BUF, M/S}
//   auto_eoi_config, u8086_mode     : ICW4 AEOI, uPM
//   interrupt_mask                  : OCW1 byte
//   ocw2_valid, ocw2_command, ocw2_level : OCW2 pulse, {R,SL,EOI}, L2..L0
//   enable_read_register, read_register_isr_or_irr : OCW3 read selection
//   poll_command                    : OCW3 poll pulse
//   special_mask_mode               : OCW3 special mask mode state
module pic_command_sequencer #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  write_strobe,
    input  logic                  A0,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  init_busy,
    output logic                  pic_ready,
    output logic                  level_or_edge_triggered_config,
    output logic                  single_or_cascade_config,
    output logic [4:0]            vector_base,
    output logic [7:0]            cascade_config,
    output logic                  special_fully_nest_config,
    output logic [1:0]            buffered_mode_config,
    output logic                  auto_eoi_config,
    output logic                  u8086_mode,
    output logic [7:0]            interrupt_mask,
    output logic                  ocw2_valid,
    output logic [2:0]            ocw2_command,
    output logic [2:0]            ocw2_level,
    output logic                  enable_read_register,
    output logic                  read_register_isr_or_irr,
    output logic                  poll_command,
    output logic                  special_mask_mode
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_ICW2,
        S_WAIT_ICW3,
        S_WAIT_ICW4,
        S_READY
    } state_t;

    state_t      state_q, state_d;
    logic        ltim_q, ltim_d;
    logic        sngl_q, sngl_d;
    logic        ic4_q, ic4_d;
    logic [4:0]  vbase_q, vbase_d;
    logic [7:0]  casc_q, casc_d;
    logic        sfnm_q, sfnm_d;
    logic [1:0]  buf_q, buf_d;
    logic        aeoi_q, aeoi_d;
    logic        upm_q, upm_d;
    logic [7:0]  mask_q, mask_d;
    logic        ocw2_v_q, ocw2_v_d;
    logic [2:0]  ocw2_cmd_q, ocw2_cmd_d;
    logic [2:0]  ocw2_lvl_q, ocw2_lvl_d;
    logic        err_q, err_d;
    logic        ris_q, ris_d;
    logic        poll_q, poll_d;
`ifdef PIC_SPECIAL_MASK_EN
    logic        smm_q, smm_d;
`endif

    logic is_icw1, is_ocw2, is_ocw3, is_a0;

    // ICW1 is recognised by D4 regardless of state; OCW2/OCW3 share A0=0, D4=0
    // and are split by D3.
    assign is_icw1 = write_strobe & ~A0 &  data_in[4];
    assign is_ocw2 = write_strobe & ~A0 & ~data_in[4] & ~data_in[3];
    assign is_ocw3 = write_strobe & ~A0 & ~data_in[4] &  data_in[3];
    assign is_a0   = write_strobe &  A0;

    always_comb begin
        state_d    = state_q;
        ltim_d     = ltim_q;
        sngl_d     = sngl_q;
        ic4_d      = ic4_q;
        vbase_d    = vbase_q;
        casc_d     = casc_q;
        sfnm_d     = sfnm_q;
        buf_d      = buf_q;
        aeoi_d     = aeoi_q;
        upm_d      = upm_q;
        mask_d     = mask_q;
        ocw2_v_d   = 1'b0;
        ocw2_cmd_d = ocw2_cmd_q;
        ocw2_lvl_d = ocw2_lvl_q;
        err_d      = err_q;
        ris_d      = ris_q;
        poll_d     = 1'b0;
`ifdef PIC_SPECIAL_MASK_EN
        smm_d      = smm_q;
`endif

        if (is_icw1) begin
            ltim_d  = data_in[3];
            sngl_d  = data_in[1];
            ic4_d   = data_in[0];
            mask_d  = '0;
            sfnm_d  = 1'b0;
            buf_d   = '0;
            aeoi_d  = 1'b0;
            upm_d   = 1'b0;
            err_d   = 1'b1;
            ris_d   = 1'b0;
`ifdef PIC_SPECIAL_MASK_EN
            smm_d   = 1'b0;
`endif
            state_d = S_WAIT_ICW2;
        end else if (is_a0) begin
            unique case (state_q)
                S_WAIT_ICW2: begin
                    vbase_d = data_in[7:3];
                    if (!sngl_q)    state_d = S_WAIT_ICW3;
                    else if (ic4_q) state_d = S_WAIT_ICW4;
                    else            state_d = S_READY;
                end
                S_WAIT_ICW3: begin
                    casc_d  = data_in[7:0];
                    state_d = ic4_q ? S_WAIT_ICW4 : S_READY;
                end
                S_WAIT_ICW4: begin
                    sfnm_d  = data_in[4];
                    buf_d   = data_in[3:2];
                    aeoi_d  = data_in[1];
                    upm_d   = data_in[0];
                    state_d = S_READY;
                end
                S_READY: mask_d = data_in[7:0];
                default: ;
            endcase
        end else if (state_q == S_READY) begin
            if (is_ocw2) begin
                ocw2_v_d   = 1'b1;
                ocw2_cmd_d = data_in[7:5];
                ocw2_lvl_d = data_in[2:0];
            end
            if (is_ocw3) begin
                if (data_in[1]) begin
                    err_d = 1'b1;
                    ris_d = data_in[0];
                end
                poll_d = data_in[2];
`ifdef PIC_SPECIAL_MASK_EN
                if (data_in[6]) smm_d = data_in[5];
`endif
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            ltim_q     <= 1'b0;
            sngl_q     <= 1'b0;
            ic4_q      <= 1'b0;
            vbase_q    <= '0;
            casc_q     <= '0;
            sfnm_q     <= 1'b0;
            buf_q      <= '0;
            aeoi_q     <= 1'b0;
            upm_q      <= 1'b0;
            mask_q     <= '0;
            ocw2_v_q   <= 1'b0;
            ocw2_cmd_q <= '0;
            ocw2_lvl_q <= '0;
            err_q      <= 1'b0;
            ris_q      <= 1'b0;
            poll_q     <= 1'b0;
`ifdef PIC_SPECIAL_MASK_EN
            smm_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            ltim_q     <= ltim_d;
            sngl_q     <= sngl_d;
            ic4_q      <= ic4_d;
            vbase_q    <= vbase_d;
            casc_q     <= casc_d;
            sfnm_q     <= sfnm_d;
            buf_q      <= buf_d;
            aeoi_q     <= aeoi_d;
            upm_q      <= upm_d;
            mask_q     <= mask_d;
            ocw2_v_q   <= ocw2_v_d;
            ocw2_cmd_q <= ocw2_cmd_d;
            ocw2_lvl_q <= ocw2_lvl_d;
            err_q      <= err_d;
            ris_q      <= ris_d;
            poll_q     <= poll_d;
`ifdef PIC_SPECIAL_MASK_EN
            smm_q      <= smm_d;
`endif
        end
    end

    assign init_busy = (state_q == S_WAIT_ICW2) || (state_q == S_WAIT_ICW3) ||
                       (state_q == S_WAIT_ICW4);
    assign pic_ready = (state_q == S_READY);

    assign level_or_edge_triggered_config = ltim_q;
    assign single_or_cascade_config       = sngl_q;
    assign vector_base                    = vbase_q;
    assign cascade_config                 = casc_q;
    assign special_fully_nest_config      = sfnm_q;
    assign buffered_mode_config           = buf_q;
    assign auto_eoi_config                = aeoi_q;
    assign u8086_mode                     = upm_q;
    assign interrupt_mask                 = mask_q;
    assign ocw2_valid                     = ocw2_v_q;
    assign ocw2_command                   = ocw2_cmd_q;
    assign ocw2_level                     = ocw2_lvl_q;
    assign enable_read_register           = err_q;
    assign read_register_isr_or_irr       = ris_q;
    assign poll_command                   = poll_q;
`ifdef PIC_SPECIAL_MASK_EN
    assign special_mask_mode              = smm_q;
`else
    assign special_mask_mode              = 1'b0;
`endif

endmodule

// File: tb/tb_pic_command_sequencer.sv
// Testbench for pic_command_sequencer. Stimulus drives one directed write (or
// idle/reset cycle) per clock and queues the hand-computed expected output
// vector; a monitor pops and compares one entry for every cycle the stimulus
// marked as observed.
module tb_pic_command_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic       write_strobe;
    logic       A0;
    logic [7:0] data_in;

    logic       init_busy, pic_ready, ltim, sngl;
    logic [4:0] vector_base;
    logic [7:0] cascade_config;
    logic       sfnm;
    logic [1:0] bufm;
    logic       aeoi, u86;
    logic [7:0] interrupt_mask;
    logic       ocw2_valid;
    logic [2:0] ocw2_command, ocw2_level;
    logic       en_rr, ris, poll, smm;

    pic_command_sequencer #(.DATA_WIDTH(8)) dut (
        .clock                          (clock),
        .reset                          (reset),
        .write_strobe                   (write_strobe),
        .A0                             (A0),
        .data_in                        (data_in),
        .init_busy                      (init_busy),
        .pic_ready                      (pic_ready),
        .level_or_edge_triggered_config (ltim),
        .single_or_cascade_config       (sngl),
        .vector_base                    (vector_base),
        .cascade_config                 (cascade_config),
        .special_fully_nest_config      (sfnm),
        .buffered_mode_config           (bufm),
        .auto_eoi_config                (aeoi),
        .u8086_mode                     (u86),
        .interrupt_mask                 (interrupt_mask),
        .ocw2_valid                     (ocw2_valid),
        .ocw2_command                   (ocw2_command),
        .ocw2_level                     (ocw2_level),
        .enable_read_register           (en_rr),
        .read_register_isr_or_irr       (ris),
        .poll_command                   (poll),
        .special_mask_mode              (smm)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic [40:0] v;
    } exp_t;

    exp_t sb[$];
    logic chk;
    int   checks;
    int   errors;

    // Hand-maintained expected field values, set by the stimulus before each step.
    logic       e_busy, e_ready, e_ltim, e_sngl;
    logic [4:0] e_vb;
    logic [7:0] e_casc;
    logic       e_sfnm;
    logic [1:0] e_buf;
    logic       e_aeoi, e_u86;
    logic [7:0] e_mask;
    logic       e_v;
    logic [2:0] e_cmd, e_lvl;
    logic       e_en, e_ris, e_poll, e_smm;

    logic [40:0] obs;
    assign obs = {init_busy, pic_ready, ltim, sngl, vector_base, cascade_config, sfnm, bufm,
                  aeoi, u86, interrupt_mask, ocw2_valid, ocw2_command, ocw2_level, en_rr, ris,
                  poll, smm};

    function automatic logic [40:0] pack_exp();
        return {e_busy, e_ready, e_ltim, e_sngl, e_vb, e_casc, e_sfnm, e_buf, e_aeoi, e_u86,
                e_mask, e_v, e_cmd, e_lvl, e_en, e_ris, e_poll, e_smm};
    endfunction

    task automatic clr_exp();
        {e_busy, e_ready, e_ltim, e_sngl, e_vb, e_casc, e_sfnm, e_buf, e_aeoi, e_u86,
         e_mask, e_v, e_cmd, e_lvl, e_en, e_ris, e_poll, e_smm} = '0;
    endtask

    task automatic push(input string n);
        exp_t e;
        e.name = n;
        e.v    = pack_exp();
        sb.push_back(e);
    endtask

    task automatic step(input logic s, input logic a, input logic [7:0] d, input string n);
        @(negedge clock);
        write_strobe = s;
        A0           = a;
        data_in      = d;
        chk          = 1'b1;
        push(n);
    endtask

    task automatic rst_step(input logic r, input string n);
        @(negedge clock);
        reset        = r;
        write_strobe = 1'b0;
        A0           = 1'b0;
        data_in      = 8'h00;
        chk          = 1'b1;
        push(n);
    endtask

    // Monitor: every cycle whose posedge was marked observed is compared at the next negedge.
    initial begin : monitor
        logic s;
        exp_t e;
        forever begin
            @(posedge clock);
            s = chk;
            @(negedge clock);
            if (s) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL %s: scoreboard empty, got %h", "underflow", obs);
                end else begin
                    e = sb.pop_front();
                    if (obs !== e.v) begin
                        errors++;
                        $display("FAIL %s: got %h expected %h", e.name, obs, e.v);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    logic smm_on;

    initial begin : stimulus
        checks = 0;
        errors = 0;
`ifdef PIC_SPECIAL_MASK_EN
        smm_on = 1'b1;
`else
        smm_on = 1'b0;
`endif
        reset = 1'b1; write_strobe = 1'b0; A0 = 1'b0; data_in = 8'h00; chk = 1'b0;
        clr_exp();

        rst_step(1'b1, "reset");
        rst_step(1'b0, "post_reset");
        step(1'b1, 1'b0, 8'h20, "idle_ocw2_ignored");
        step(1'b1, 1'b1, 8'h55, "idle_a0_ignored");

        // Init 1: ICW1=0x13 (SNGL, IC4) -> ICW2 -> ICW4.
        e_busy = 1; e_sngl = 1; e_en = 1;
        step(1'b1, 1'b0, 8'h13, "icw1_13");
        step(1'b1, 1'b0, 8'h20, "busy_ocw2_ignored");
        step(1'b1, 1'b0, 8'h0B, "busy_ocw3_ignored");
        e_vb = 5'h09;
        step(1'b1, 1'b1, 8'h48, "icw2_48");
        e_busy = 0; e_ready = 1; e_aeoi = 1; e_u86 = 1;
        step(1'b1, 1'b1, 8'h03, "icw4_03");

        e_mask = 8'hFB;
        step(1'b1, 1'b1, 8'hFB, "ocw1_fb");
        e_v = 1; e_cmd = 3'b001; e_lvl = 3'd0;
        step(1'b1, 1'b0, 8'h20, "ocw2_20");
        e_v = 0;
        step(1'b0, 1'b0, 8'h00, "ocw2_pulse_end");
        e_v = 1; e_cmd = 3'b011; e_lvl = 3'd7;
        step(1'b1, 1'b0, 8'h67, "ocw2_67_b2b");
        e_cmd = 3'b111; e_lvl = 3'd3;
        step(1'b1, 1'b0, 8'hE3, "ocw2_e3_b2b");
        e_v = 0;
        step(1'b0, 1'b0, 8'h00, "ocw2_b2b_end");

        e_ris = 1;
        step(1'b1, 1'b0, 8'h0B, "ocw3_0b_isr");
        step(1'b1, 1'b0, 8'h08, "ocw3_08_hold");
        e_poll = 1;
        step(1'b1, 1'b0, 8'h0C, "ocw3_0c_poll");
        e_poll = 0;
        step(1'b0, 1'b0, 8'h00, "poll_pulse_end");
        e_ris = 0;
        step(1'b1, 1'b0, 8'h0A, "ocw3_0a_irr");

        e_smm = smm_on;
        step(1'b1, 1'b0, 8'h68, "ocw3_68_smm_set");
        step(1'b1, 1'b0, 8'h08, "ocw3_08_smm_hold");
        e_smm = 0;
        step(1'b1, 1'b0, 8'h48, "ocw3_48_smm_clr");
        e_smm = smm_on;
        step(1'b1, 1'b0, 8'h68, "ocw3_68_smm_set2");

        // Init 2: ICW1=0x11 (cascade, IC4) passes through WAIT_ICW3.
        e_busy = 1; e_ready = 0; e_sngl = 0; e_mask = 8'h00; e_aeoi = 0; e_u86 = 0;
        e_en = 1; e_ris = 0; e_smm = 0;
        step(1'b1, 1'b0, 8'h11, "icw1_11");
        e_vb = 5'h04;
        step(1'b1, 1'b1, 8'h20, "icw2_20");
        e_casc = 8'h04;
        step(1'b1, 1'b1, 8'h04, "icw3_04");
        e_busy = 0; e_ready = 1; e_sfnm = 1; e_buf = 2'b11; e_u86 = 1;
        step(1'b1, 1'b1, 8'h1D, "icw4_1d");
        e_mask = 8'h3C;
        step(1'b1, 1'b1, 8'h3C, "ocw1_3c");

        // Init 3: ICW1 again while in WAIT_ICW3 restarts the sequence.
        e_busy = 1; e_ready = 0; e_ltim = 1; e_mask = 8'h00; e_sfnm = 0; e_buf = 2'b00;
        e_u86 = 0;
        step(1'b1, 1'b0, 8'h19, "icw1_19");
        e_vb = 5'h01;
        step(1'b1, 1'b1, 8'h08, "icw2_08_to_icw3");
        e_sngl = 1;
        step(1'b1, 1'b0, 8'h1A, "icw1_restart");
        e_busy = 0; e_ready = 1; e_vb = 5'h1F;
        step(1'b1, 1'b1, 8'hF8, "icw2_f8_ready");
        e_mask = 8'h12;
        step(1'b1, 1'b1, 8'h12, "ocw1_12");

        // Reset in the middle of an init sequence.
        e_busy = 1; e_ready = 0; e_ltim = 0; e_mask = 8'h00; e_u86 = 0;
        step(1'b1, 1'b0, 8'h13, "icw1_before_reset");
        clr_exp();
        rst_step(1'b1, "reset_mid_init");
        rst_step(1'b0, "after_reset_release");
        step(1'b1, 1'b1, 8'hAA, "after_reset_a0_ignored");

        @(negedge clock);
        write_strobe = 1'b0;
        chk          = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
